// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing and types for the 16 x 8-bit register file.
//   DATA_W     register / ALU operand width
//   NREGS      architectural register count (power of two)
//   ADDR_W     register index width, log2(NREGS)
//   ZERO_REG   index of the hardwired-zero register
//   reg_data_t one register's worth of data
package regfile_pkg;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREGS  = 16;
  localparam int unsigned ADDR_W = 4;

  localparam logic [ADDR_W-1:0] ZERO_REG = 4'd0;

  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/reg8_en.sv
// reg8_en: one W-bit register with synchronous active-high reset and load enable.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset, overrides en
//   en   in  load enable
//   d    in  W-bit load data
//   q    out W-bit stored value
module reg8_en
  import regfile_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/reg_file_8x16.sv
// reg_file_8x16: 16-entry x 8-bit register file, two combinational read ports,
// one clocked write port. R0 is hardwired to zero.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (clears all registers and wr_ack)
//   rs1_addr  in   read port 1 index
//   rs2_addr  in   read port 2 index
//   rs1_data  out  read port 1 data (ALU in1)
//   rs2_data  out  read port 2 data (ALU in2)
//   we        in   write enable
//   rd_addr   in   write index
//   rd_data   in   write data
//   wr_ack    out  registered one-cycle pulse per committed write
// Optional feature: define REGFILE_BYPASS_EN to forward rd_data to a read port
// addressing the register being written in the same cycle (write-through).
module reg_file_8x16
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned NREGS  = regfile_pkg::NREGS,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_ack
);

  // regs[0] is tied to zero so the read mux never sees an undriven entry.
  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic                         wr_commit;
  logic                         wr_ack_d, wr_ack_q;
  logic [DATA_W-1:0]            rs1_raw, rs2_raw;

  // A write commits only when it targets a real register.
  assign wr_commit = we && (rd_addr != ZERO_REG);

  assign regs[0] = '0;

  // R1..R(NREGS-1); load enable is the one-hot decode of rd_addr gated by we.
  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    logic wen;
    assign wen = we && (rd_addr == ADDR_W'(i));
    reg8_en #(.W(DATA_W)) u_reg (
      .clk (clk),
      .rst (rst),
      .en  (wen),
      .d   (rd_data),
      .q   (regs[i])
    );
  end

  // Read muxes with explicit R0 zero-force.
  always_comb begin
    rs1_raw = (rs1_addr == ZERO_REG) ? '0 : regs[rs1_addr];
    rs2_raw = (rs2_addr == ZERO_REG) ? '0 : regs[rs2_addr];
  end

`ifdef REGFILE_BYPASS_EN
  // Forward the in-flight write; suppressed during reset since that write is discarded.
  always_comb begin
    rs1_data = rs1_raw;
    rs2_data = rs2_raw;
    if (!rst && wr_commit && (rs1_addr == rd_addr)) rs1_data = rd_data;
    if (!rst && wr_commit && (rs2_addr == rd_addr)) rs2_data = rd_data;
  end
`else
  assign rs1_data = rs1_raw;
  assign rs2_data = rs2_raw;
`endif

  always_comb begin
    wr_ack_d = wr_commit;
  end

  always_ff @(posedge clk) begin
    if (rst) wr_ack_q <= 1'b0;
    else     wr_ack_q <= wr_ack_d;
  end

  assign wr_ack = wr_ack_q;

endmodule

// File: tb/tb_reg_file_8x16.sv
module tb_reg_file_8x16;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rs1_addr, rs2_addr, rd_addr;
  logic [7:0] rs1_data, rs2_data, rd_data;
  logic       we;
  logic       wr_ack;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_file_8x16 dut (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (we),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_ack   (wr_ack)
  );

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; rd_addr = 4'd0; rd_data = 8'h00;
    rs1_addr = 4'd0; rs2_addr = 4'd0;
    tick(); tick();
    rst = 1'b0;
    #1;
    tests++;
    if (wr_ack !== 1'b0) begin
      fails++; $display("FAIL reset_ack: got %b want 0", wr_ack);
    end
    // Fill R1..R15 with A5, then a one-cycle reset pulse.
    for (int i = 1; i < 16; i++) begin
      we = 1'b1; rd_addr = 4'(i); rd_data = 8'hA5;
      tick();
    end
    we = 1'b0;
    rs1_addr = 4'd5; #1;
    tests++;
    if (rs1_data !== 8'hA5) begin
      fails++; $display("FAIL fill_r5: got %h want a5", rs1_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      rs1_addr = 4'(i); rs2_addr = 4'(15 - i); #1;
      tests++;
      if (rs1_data !== 8'h00 || rs2_data !== 8'h00) begin
        fails++;
        $display("FAIL reset_clear[%0d]: rs1=%h rs2=%h want 00", i, rs1_data, rs2_data);
      end
    end
    tests++;
    if (wr_ack !== 1'b0) begin
      fails++; $display("FAIL reset_clear_ack: got %b want 0", wr_ack);
    end
  endtask

  task automatic test_basic();
    we = 1'b1; rd_addr = 4'd3; rd_data = 8'h5C;
    tick();
    we = 1'b0; rs1_addr = 4'd3; rs2_addr = 4'd3; #1;
    tests++;
    if (rs1_data !== 8'h5C || rs2_data !== 8'h5C) begin
      fails++; $display("FAIL basic_rd: rs1=%h rs2=%h want 5c", rs1_data, rs2_data);
    end
    tests++;
    if (wr_ack !== 1'b1) begin
      fails++; $display("FAIL basic_ack: got %b want 1", wr_ack);
    end
    tick();
    tests++;
    if (wr_ack !== 1'b0) begin
      fails++; $display("FAIL basic_ack_pulse: got %b want 0", wr_ack);
    end
    tests++;
    if (rs1_data !== 8'h5C) begin
      fails++; $display("FAIL basic_hold: got %h want 5c", rs1_data);
    end
  endtask

  task automatic test_r0();
    we = 1'b1; rd_addr = 4'd0; rd_data = 8'hFF; rs1_addr = 4'd0; #1;
    tests++;
    if (rs1_data !== 8'h00) begin
      fails++; $display("FAIL r0_pre: got %h want 00", rs1_data);
    end
    tick();
    we = 1'b0; #1;
    tests++;
    if (rs1_data !== 8'h00 || wr_ack !== 1'b0) begin
      fails++; $display("FAIL r0_post: rs1=%h ack=%b want 00/0", rs1_data, wr_ack);
    end
  endtask

  task automatic test_hazard();
    logic [7:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 8'h22;
`else
    exp_pre = 8'h11;
`endif
    we = 1'b1; rd_addr = 4'd7; rd_data = 8'h11;
    tick();
    rd_data = 8'h22; rs1_addr = 4'd7; rs2_addr = 4'd3; #1;
    tests++;
    if (rs1_data !== exp_pre) begin
      fails++; $display("FAIL hazard_pre: got %h want %h", rs1_data, exp_pre);
    end
    tests++;
    if (rs2_data !== 8'h5C) begin
      fails++; $display("FAIL hazard_other_port: got %h want 5c", rs2_data);
    end
    tick();
    we = 1'b0; #1;
    tests++;
    if (rs1_data !== 8'h22) begin
      fails++; $display("FAIL hazard_post: got %h want 22", rs1_data);
    end
  endtask

  task automatic test_rst_collision();
    we = 1'b1; rd_addr = 4'd9; rd_data = 8'h55;
    tick();
    rst = 1'b1; rd_data = 8'h3C; rs1_addr = 4'd9; #1;
    // During reset no forwarding: the stored 55 is seen.
    tests++;
    if (rs1_data !== 8'h55) begin
      fails++; $display("FAIL collide_pre: got %h want 55", rs1_data);
    end
    tick();
    rst = 1'b0; we = 1'b0; #1;
    tests++;
    if (rs1_data !== 8'h00 || wr_ack !== 1'b0) begin
      fails++; $display("FAIL collide_post: rs1=%h ack=%b want 00/0", rs1_data, wr_ack);
    end
  endtask

  task automatic test_soak();
    logic [7:0] model [16];
    logic [7:0] e1, e2;
    logic       exp_ack, prev_ack;
    int         b2b;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    prev_ack = 1'b0;
    b2b = 0;
    for (int c = 0; c < 2000; c++) begin
      we       = ($urandom_range(0, 3) != 0);
      rd_addr  = 4'($urandom_range(0, 15));
      rd_data  = 8'($urandom);
      rs1_addr = 4'($urandom_range(0, 15));
      rs2_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 4'($urandom_range(0, 15));
      #1;
      e1 = (rs1_addr == 0) ? 8'h00 : model[rs1_addr];
      e2 = (rs2_addr == 0) ? 8'h00 : model[rs2_addr];
`ifdef REGFILE_BYPASS_EN
      if (we && rd_addr != 0 && rs1_addr == rd_addr) e1 = rd_data;
      if (we && rd_addr != 0 && rs2_addr == rd_addr) e2 = rd_data;
`endif
      tests++;
      if (rs1_data !== e1 || rs2_data !== e2) begin
        fails++;
        $display("FAIL soak_rd cyc %0d: rs1[%0d]=%h want %h rs2[%0d]=%h want %h",
                 c, rs1_addr, rs1_data, e1, rs2_addr, rs2_data, e2);
      end
      exp_ack = we && (rd_addr != 0);
      tick();
      if (exp_ack) model[rd_addr] = rd_data;
      tests++;
      if (wr_ack !== exp_ack) begin
        fails++; $display("FAIL soak_ack cyc %0d: got %b want %b", c, wr_ack, exp_ack);
      end
      if (exp_ack && prev_ack) b2b++;
      prev_ack = exp_ack;
    end
    we = 1'b0;
    tests++;
    if (b2b == 0) begin
      fails++; $display("FAIL soak_b2b: no back-to-back writes exercised");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_r0();
    test_hazard();
    test_rst_collision();
    test_soak();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
